// File: rtl/kernel_sum_arb.sv
// kernel_sum_arb: round-robin arbiter sharing one kernel_sum engine among N_REQ
// pixel pipelines, returning each in-order result to the requester that issued it.
module kernel_sum_arb #(
   parameter int N_REQ = 2,
   parameter int DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ-1:0][48:0][31:0]  req_kernel,
   output logic [N_REQ-1:0]              req_ready,
   output logic [48:0][31:0]             kernel,
   output logic                          kernel_valid,
   input  logic [31:0]                   sum,
   input  logic                          sum_valid,
   output logic [N_REQ-1:0]              rsp_valid,
   output logic [31:0]                   rsp_sum,
   output logic [$clog2(DEPTH):0]        outstanding,
   output logic                          tag_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(N_REQ);
   localparam int SW = TW + 1;
   localparam int CW = AW + 1;

   logic [TW-1:0]    ptr;
   logic [TW-1:0]    grant_idx;
   logic             grant_found;
   logic [TW-1:0]    ptr_next;
   logic             full;
   logic             empty;
   logic             accept;
   logic             pop;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [TW-1:0]    tag_mem [DEPTH];
   logic [TW-1:0]    head_tag;
   logic [N_REQ-1:0] rsp_onehot;
   logic [SW-1:0]    slot_w;
   logic [TW-1:0]    slot;

   // Full is judged on the registered count, so a pop never frees a slot in its own cycle.
   assign full     = (outstanding == CW'(DEPTH));
   assign empty    = (outstanding == '0);
   assign accept   = rst_n && !full && grant_found;
   assign pop      = sum_valid && !empty;
   assign head_tag = tag_mem[rd_ptr];
   assign ptr_next = (grant_idx == TW'(N_REQ - 1)) ? '0 : grant_idx + TW'(1);

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      slot_w      = '0;
      slot        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         slot_w = {1'b0, ptr} + SW'(k);
         if (slot_w >= SW'(N_REQ)) slot_w = slot_w - SW'(N_REQ);
         slot = slot_w[TW-1:0];
         if (!grant_found && req_valid[slot]) begin
            grant_found = 1'b1;
            grant_idx   = slot;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      rsp_onehot           = '0;
      rsp_onehot[head_tag] = 1'b1;
   end

   // Tag storage holds no state that matters after reset: the pointers define occupancy.
   always_ff @(posedge clk) begin
      if (accept) tag_mem[wr_ptr] <= grant_idx;
   end

   // Stage boundary: grant -> issue to kernel_sum, and sum_valid -> response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr          <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         outstanding  <= '0;
         kernel_valid <= 1'b0;
         kernel       <= '0;
         rsp_valid    <= '0;
         rsp_sum      <= '0;
         tag_err      <= 1'b0;
      end else begin
         kernel_valid <= accept;
         if (accept) begin
            kernel <= req_kernel[grant_idx];
            wr_ptr <= wr_ptr + AW'(1);
            ptr    <= ptr_next;
         end
         rsp_valid <= '0;
         if (pop) begin
            rsp_valid <= rsp_onehot;
            rsp_sum   <= sum;
            rd_ptr    <= rd_ptr + AW'(1);
         end
         if (sum_valid && empty) tag_err <= 1'b1;
         if (accept && !pop)      outstanding <= outstanding + CW'(1);
         else if (pop && !accept) outstanding <= outstanding - CW'(1);
      end
   end

endmodule
